ibex_fault_mgr: RTL
===================

# ibex_fault_mgr

Central collector for the per-register error pulses (`*_new_maj_err_o`, `*_new_min_err_o`, `*_scrub_occurred_o`) emitted by hardened Ibex registers such as the CSR primitives. It counts major errors, minor errors and scrubs with saturating counters, and keeps sticky per-source masks. It also captures the first major-error source, drives a health state machine with a registered alert, and offers a 1-cycle-latency read port for the debug/metrics bus.

## Interface
Parameters:
- `NumSrc`, 8: number of error sources; valid range 1..32.
- `CntWidth`, 16: width of each event counter; valid range 4..32.
- `MajThresh`, 1: major-error count at which the state goes to FAILED; valid range 1..2^CntWidth-1.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset. The block uses one clock; reset is asynchronous and active-low.
- `src_maj_err_i`  in  NumSrc  one-cycle major-error pulses, one bit per source.
- `src_min_err_i`  in  NumSrc  one-cycle minor-error pulses.
- `src_scrub_i`  in  NumSrc  one-cycle scrub-occurred pulses.
- `clear_i`  in  1  synchronous clear of counters, masks, first-source capture and state.
- `rd_req_i`  in  1  read request.
- `rd_addr_i`  in  3  read register select.
- `rd_valid_o`  out  1  read data valid.
- `rd_data_o`  out  32  read data.
- `alert_maj_o`  out  1  high while the state is FAILED.
- `first_vld_o`  out  1  a first major-error source has been captured.
- `first_src_o`  out  5  index of the first major-error source.

## Operation
- Each cycle, compute a popcount of each pulse vector. The popcount width is `$clog2(NumSrc+1)`.
- Add each popcount to its counter, zero-extended. Saturate at all-ones; a saturated counter never wraps.
- Sticky masks: `maj_mask |= src_maj_err_i` and `min_mask |= src_min_err_i`.
- First-source capture: while `first_vld` is 0 and any major bit is set, latch the lowest set index and set `first_vld`. Later pulses never overwrite the capture.
- `clear_i`:
  - Counters load that cycle's popcount, not 0.
  - Masks load that cycle's vectors.
  - First-source capture restarts from that cycle's vector.
  - The state is re-evaluated from the post-clear values.
- Health state machine. States OK=0, DEGRADED=1, FAILED=2 are evaluated on the next-cycle counter values:
  - FAILED if `maj_cnt >= MajThresh`.
  - Otherwise DEGRADED if `min_cnt != 0`.
  - Otherwise OK.
  - FAILED is left only through `clear_i` or reset.
  - OK→DEGRADED→FAILED can be skipped directly.
- Read map. All fields are zero-extended to 32 bits:
  - 0: `maj_cnt`
  - 1: `min_cnt`
  - 2: `scrub_cnt`
  - 3: `maj_mask`
  - 4: `min_mask`
  - 5: `{first_src[12:8], first_vld[4], state[1:0]}`
  - 6–7: 0
- Reset values:
  - All counters, masks, `first_src_o`, `first_vld_o`, `alert_maj_o`, `rd_valid_o` and `rd_data_o` are 0.
  - State is OK.

## Timing
- A pulse at edge N is visible in the counters, masks and status after edge N.
- `alert_maj_o` is a registered output. It rises on the edge that makes `maj_cnt` reach `MajThresh`, i.e. at the same time as the counter.
- Read:
  - `rd_req_i` is sampled at edge N; `rd_valid_o` and `rd_data_o` are valid after edge N for exactly one cycle.
  - The data are the register values before edge N, so pulses or clears in the request cycle are excluded.
  - Back-to-back requests are accepted every cycle; there is no stall.
  - `rd_data_o` holds its last value when `rd_valid_o` is 0.
- Reset mid-operation:
  - All state clears asynchronously.
  - A read in flight is dropped: `rd_valid_o` is 0 after reset release until a new request arrives.
- Simultaneous clear and read: the read returns the pre-clear values.

## Structure
- Package `ibex_fault_pkg` holds:
  - `fault_state_e` (OK/DEGRADED/FAILED).
  - Read address constants `FAULT_ADDR_MAJ_CNT` through `FAULT_ADDR_STATUS`.
  - The status field bit positions.
- Sub-module `ibex_fault_sat_cnt`, instantiated three times, is a saturating accumulator with parameters `Width` and `IncWidth` and ports `clk_i`, `rst_ni`, `clr_i`, `inc_i`, `cnt_o`.
- The popcount is a local function in the top module.

## Test plan
- Reset, then read addresses 0–7 → every read returns 0 and `alert_maj_o`=0.
- `src_min_err_i`=8'b0000_0101 for 1 cycle, then read address 1 → returns 2; status reads 0x1 (DEGRADED).
- `src_maj_err_i`=8'b1010_0000, then 8'b0000_0010, with `MajThresh`=3:
  - `alert_maj_o` rises one cycle after the second pulse.
  - `first_src_o`=5.
  - Read address 3 returns 0xA2.
- `CntWidth`=4 with `src_scrub_i`=8'hFF for 2 cycles → `scrub_cnt` saturates at 15 and stays 15 after further pulses.
- `clear_i` together with `src_maj_err_i`=8'h01, with `MajThresh`=1 → `maj_cnt`=1, `first_src_o`=0, state stays FAILED.
- Same test, with `rd_req_i` asserted in that cycle → the read returns the pre-clear count.
- Assert `rst_ni` low in the cycle after `rd_req_i` → `rd_valid_o` never pulses and all outputs are 0.

Source files
------------

// File: rtl/ibex_fault_pkg.sv
// Shared types and constants for the Ibex fault manager: health states,
// read-port register map and status-word field positions.
package ibex_fault_pkg;

    typedef enum logic [1:0] {
        FAULT_OK       = 2'd0,
        FAULT_DEGRADED = 2'd1,
        FAULT_FAILED   = 2'd2
    } fault_state_e;

    localparam logic [2:0] FAULT_ADDR_MAJ_CNT  = 3'd0;
    localparam logic [2:0] FAULT_ADDR_MIN_CNT  = 3'd1;
    localparam logic [2:0] FAULT_ADDR_SCRUB    = 3'd2;
    localparam logic [2:0] FAULT_ADDR_MAJ_MASK = 3'd3;
    localparam logic [2:0] FAULT_ADDR_MIN_MASK = 3'd4;
    localparam logic [2:0] FAULT_ADDR_STATUS   = 3'd5;

    localparam int unsigned STATUS_STATE_LSB     = 0;
    localparam int unsigned STATUS_FIRST_VLD_BIT = 4;
    localparam int unsigned STATUS_FIRST_SRC_LSB = 8;

endpackage

// File: rtl/ibex_fault_sat_cnt.sv
// Saturating accumulator: adds inc_i every cycle and sticks at all-ones.
// clr_i restarts accumulation from zero while still adding that cycle's inc_i.
module ibex_fault_sat_cnt #(
    parameter int unsigned Width    = 16,
    parameter int unsigned IncWidth = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic [IncWidth-1:0] inc_i,
    output logic [Width-1:0]    cnt_o
);

    // Sum is wide enough for whichever operand is wider, so a large increment
    // into a narrow counter still saturates instead of truncating.
    localparam int unsigned SumW = ((Width > IncWidth) ? Width : IncWidth) + 1;

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;
    logic [Width-1:0] base_s;
    logic [SumW-1:0]  sum_s;

    // Next-count computation with saturation.
    always_comb begin
        base_s = '0;
        cnt_d  = cnt_q;
        if (clr_i) begin
            base_s = '0;
        end else begin
            base_s = cnt_q;
        end
        sum_s = SumW'(base_s) + SumW'(inc_i);
        if (sum_s > SumW'({Width{1'b1}})) begin
            cnt_d = {Width{1'b1}};
        end else begin
            cnt_d = sum_s[Width-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ibex_fault_mgr.sv
// Collects per-register error/scrub pulses from hardened Ibex registers into
// saturating counters, sticky masks, a first-fault capture and a health FSM.
module ibex_fault_mgr
    import ibex_fault_pkg::*;
#(
    parameter int unsigned NumSrc    = 8,
    parameter int unsigned CntWidth  = 16,
    parameter int unsigned MajThresh = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumSrc-1:0] src_maj_err_i,
    input  logic [NumSrc-1:0] src_min_err_i,
    input  logic [NumSrc-1:0] src_scrub_i,
    input  logic              clear_i,
    input  logic              rd_req_i,
    input  logic [2:0]        rd_addr_i,
    output logic              rd_valid_o,
    output logic [31:0]       rd_data_o,
    output logic              alert_maj_o,
    output logic              first_vld_o,
    output logic [4:0]        first_src_o
);

    localparam int unsigned PcW  = $clog2(NumSrc + 1);
    localparam int unsigned SumW = ((CntWidth > PcW) ? CntWidth : PcW) + 1;
    localparam logic [CntWidth-1:0] MajThreshC = CntWidth'(MajThresh);

    function automatic logic [PcW-1:0] popcount(input logic [NumSrc-1:0] v);
        logic [PcW-1:0] n;
        n = '0;
        for (int i = 0; i < NumSrc; i++) begin
            n = n + PcW'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [4:0] lowest_idx(input logic [NumSrc-1:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = NumSrc - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

    // Mirrors the accumulator's next value so the FSM sees post-edge counts.
    function automatic logic [CntWidth-1:0] sat_next(input logic [CntWidth-1:0] cnt,
                                                      input logic [PcW-1:0]      inc,
                                                      input logic                clr);
        logic [SumW-1:0] s;
        if (clr) begin
            s = SumW'(inc);
        end else begin
            s = SumW'(cnt) + SumW'(inc);
        end
        if (s > SumW'({CntWidth{1'b1}})) begin
            return {CntWidth{1'b1}};
        end else begin
            return s[CntWidth-1:0];
        end
    endfunction

    logic [PcW-1:0]      maj_pc_s, min_pc_s, scrub_pc_s;
    logic [CntWidth-1:0] maj_cnt_s, min_cnt_s, scrub_cnt_s;
    logic [CntWidth-1:0] maj_nxt_s, min_nxt_s;
    logic [NumSrc-1:0]   maj_mask_q, maj_mask_d, min_mask_q, min_mask_d;
    logic                first_vld_q, first_vld_d;
    logic [4:0]          first_src_q, first_src_d;
    fault_state_e        state_q, state_d;
    logic                alert_q;
    logic                rd_valid_q;
    logic [31:0]         rd_data_q;
    logic [31:0]         rd_mux_s;
    logic [31:0]         status_s;

    assign maj_pc_s   = popcount(src_maj_err_i);
    assign min_pc_s   = popcount(src_min_err_i);
    assign scrub_pc_s = popcount(src_scrub_i);

    ibex_fault_sat_cnt #(.Width(CntWidth), .IncWidth(PcW)) u_maj_cnt (
        .clk_i (clk_i), .rst_ni(rst_ni), .clr_i(clear_i), .inc_i(maj_pc_s), .cnt_o(maj_cnt_s)
    );
    ibex_fault_sat_cnt #(.Width(CntWidth), .IncWidth(PcW)) u_min_cnt (
        .clk_i (clk_i), .rst_ni(rst_ni), .clr_i(clear_i), .inc_i(min_pc_s), .cnt_o(min_cnt_s)
    );
    ibex_fault_sat_cnt #(.Width(CntWidth), .IncWidth(PcW)) u_scrub_cnt (
        .clk_i (clk_i), .rst_ni(rst_ni), .clr_i(clear_i), .inc_i(scrub_pc_s), .cnt_o(scrub_cnt_s)
    );

    assign maj_nxt_s = sat_next(maj_cnt_s, maj_pc_s, clear_i);
    assign min_nxt_s = sat_next(min_cnt_s, min_pc_s, clear_i);

    // Masks, first-fault capture and health state next-values.
    always_comb begin
        maj_mask_d  = maj_mask_q;
        min_mask_d  = min_mask_q;
        first_vld_d = first_vld_q;
        first_src_d = first_src_q;
        state_d     = state_q;

        if (clear_i) begin
            maj_mask_d  = src_maj_err_i;
            min_mask_d  = src_min_err_i;
            first_vld_d = |src_maj_err_i;
            first_src_d = lowest_idx(src_maj_err_i);
        end else begin
            maj_mask_d = maj_mask_q | src_maj_err_i;
            min_mask_d = min_mask_q | src_min_err_i;
            if (!first_vld_q && (|src_maj_err_i)) begin
                first_vld_d = 1'b1;
                first_src_d = lowest_idx(src_maj_err_i);
            end else begin
                first_vld_d = first_vld_q;
                first_src_d = first_src_q;
            end
        end

        // FAILED is sticky unless clear re-evaluates from the cleared counts.
        if (!clear_i && (state_q == FAULT_FAILED)) begin
            state_d = FAULT_FAILED;
        end else if (maj_nxt_s >= MajThreshC) begin
            state_d = FAULT_FAILED;
        end else if (min_nxt_s != '0) begin
            state_d = FAULT_DEGRADED;
        end else begin
            state_d = FAULT_OK;
        end
    end

    // Status word and read-address decode over the current register values.
    always_comb begin
        status_s = 32'd0;
        status_s[STATUS_STATE_LSB +: 2]     = state_q;
        status_s[STATUS_FIRST_VLD_BIT]      = first_vld_q;
        status_s[STATUS_FIRST_SRC_LSB +: 5] = first_src_q;
        case (rd_addr_i)
            FAULT_ADDR_MAJ_CNT:  rd_mux_s = 32'(maj_cnt_s);
            FAULT_ADDR_MIN_CNT:  rd_mux_s = 32'(min_cnt_s);
            FAULT_ADDR_SCRUB:    rd_mux_s = 32'(scrub_cnt_s);
            FAULT_ADDR_MAJ_MASK: rd_mux_s = 32'(maj_mask_q);
            FAULT_ADDR_MIN_MASK: rd_mux_s = 32'(min_mask_q);
            FAULT_ADDR_STATUS:   rd_mux_s = status_s;
            default:             rd_mux_s = 32'd0;
        endcase
    end

    // Fault-tracking state and registered alert.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            maj_mask_q  <= '0;
            min_mask_q  <= '0;
            first_vld_q <= 1'b0;
            first_src_q <= 5'd0;
            state_q     <= FAULT_OK;
            alert_q     <= 1'b0;
        end else begin
            maj_mask_q  <= maj_mask_d;
            min_mask_q  <= min_mask_d;
            first_vld_q <= first_vld_d;
            first_src_q <= first_src_d;
            state_q     <= state_d;
            alert_q     <= (state_d == FAULT_FAILED);
        end
    end

    // Read port: one-cycle response, data held between requests.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
        end else begin
            rd_valid_q <= rd_req_i;
            if (rd_req_i) begin
                rd_data_q <= rd_mux_s;
            end else begin
                rd_data_q <= rd_data_q;
            end
        end
    end

    assign rd_valid_o  = rd_valid_q;
    assign rd_data_o   = rd_data_q;
    assign alert_maj_o = alert_q;
    assign first_vld_o = first_vld_q;
    assign first_src_o = first_src_q;

endmodule
